// File: rtl/mips_pkg.sv
// Shared datapath widths and register-file constants for the MIPS pipeline.
// Used by the MEM/WB stage and the general-purpose register file.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic is_reg_zero(input logic [4:0] idx);
      return idx == REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_regfile_gpr_array.sv
// 2**ADDR_W x DATA_W register array: one write port, two combinational read
// ports, asynchronous clear, and register 0 held at zero.
module gpr_array #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);
   import mips_pkg::*;

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (we && !is_reg_zero(waddr))
         regs_d[waddr] = wdata;
      // Entry 0 never holds anything but zero, whatever the write port does.
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rdata1 = is_reg_zero(raddr1) ? '0 : regs_q[raddr1];
      rdata2 = is_reg_zero(raddr2) ? '0 : regs_q[raddr2];
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus GPR file: writeback mux, write qualification, retire
// counter, and an optional same-cycle read bypass enabled by WB_BYPASS_EN.
module wb_regfile #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wb_alu_data,
   input  logic [DATA_W-1:0] wb_mem_data,
   input  logic [ADDR_W-1:0] wb_dst,
   input  logic              wb_mem2reg,
   input  logic              wb_regwr,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   output logic [31:0]       retire_cnt
);
   import mips_pkg::*;

   logic [DATA_W-1:0] arr_rd1;
   logic [DATA_W-1:0] arr_rd2;
   logic [31:0]       retire_cnt_q;
   logic [31:0]       retire_cnt_d;

   always_comb begin
      wb_data = wb_mem2reg ? wb_mem_data : wb_alu_data;
      wb_we   = wb_regwr && !is_reg_zero(wb_dst);
   end

   gpr_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_gpr (
      .clk    (clk),
      .rst    (rst),
      .we     (wb_we),
      .waddr  (wb_dst),
      .wdata  (wb_data),
      .raddr1 (rd_addr1),
      .raddr2 (rd_addr2),
      .rdata1 (arr_rd1),
      .rdata2 (arr_rd2)
   );

`ifdef WB_BYPASS_EN
   // wb_we already excludes r0, so a bypass hit never exposes data on r0.
   // Reset suppresses the bypass so reads stay zero while rst is high.
   always_comb begin
      rd_data1 = (wb_we && !rst && rd_addr1 == wb_dst) ? wb_data : arr_rd1;
      rd_data2 = (wb_we && !rst && rd_addr2 == wb_dst) ? wb_data : arr_rd2;
   end
`else
   always_comb begin
      rd_data1 = arr_rd1;
      rd_data2 = arr_rd2;
   end
`endif

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (wb_we)
         retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retire_cnt_q <= '0;
      else
         retire_cnt_q <= retire_cnt_d;
   end

   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, hand-written corner
// sequences, and a randomized run against an array-based reference model.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_alu_data, wb_mem_data;
   logic [4:0]  wb_dst;
   logic        wb_mem2reg, wb_regwr;
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rd_data1, rd_data2, wb_data;
   logic        wb_we;
   logic [31:0] retire_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .wb_alu_data (wb_alu_data),
      .wb_mem_data (wb_mem_data),
      .wb_dst      (wb_dst),
      .wb_mem2reg  (wb_mem2reg),
      .wb_regwr    (wb_regwr),
      .rd_addr1    (rd_addr1),
      .rd_addr2    (rd_addr2),
      .rd_data1    (rd_data1),
      .rd_data2    (rd_data2),
      .wb_data     (wb_data),
      .wb_we       (wb_we),
      .retire_cnt  (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic regwr, input logic m2r, input logic [4:0] dst,
                        input logic [31:0] alu, input logic [31:0] mem);
      wb_regwr = regwr; wb_mem2reg = m2r; wb_dst = dst;
      wb_alu_data = alu; wb_mem_data = mem;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
   endtask

   task automatic write_reg(input logic [4:0] dst, input logic [31:0] val);
      @(negedge clk);
      drive(1'b1, 1'b0, dst, val, 32'h0);
      @(posedge clk); #1;
      idle();
   endtask

   typedef struct {
      logic        regwr, m2r;
      logic [4:0]  dst;
      logic [31:0] alu, mem;
      logic        exp_we;
      logic [31:0] exp_wd;
      logic [4:0]  raddr;
      logic [31:0] exp_rd;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t tbl[7];

   // reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   initial begin
      tbl[0] = '{1'b1, 1'b0, 5'd8,  32'hAAAA0001, 32'h55550002, 1'b1, 32'hAAAA0001, 5'd8,  32'hAAAA0001, 32'd1};
      tbl[1] = '{1'b1, 1'b1, 5'd8,  32'hAAAA0001, 32'h55550002, 1'b1, 32'h55550002, 5'd8,  32'h55550002, 32'd2};
      tbl[2] = '{1'b1, 1'b0, 5'd0,  32'hFFFFFFFF, 32'h00000000, 1'b0, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'd2};
      tbl[3] = '{1'b0, 1'b0, 5'd8,  32'h00001234, 32'h00000000, 1'b0, 32'h00001234, 5'd8,  32'h55550002, 32'd2};
      tbl[4] = '{1'b1, 1'b1, 5'd31, 32'h00000000, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 5'd31, 32'hCAFEF00D, 32'd3};
      tbl[5] = '{1'b1, 1'b0, 5'd1,  32'h00000001, 32'h99999999, 1'b1, 32'h00000001, 5'd1,  32'h00000001, 32'd4};
      tbl[6] = '{1'b1, 1'b1, 5'd0,  32'h00000000, 32'h12345678, 1'b0, 32'h12345678, 5'd0,  32'h00000000, 32'd4};

      rst = 1'b1; idle(); rd_addr1 = 5'd8; rd_addr2 = 5'd31;
      #1;
      chk("wb_we_follows_in_rst", {31'b0, wb_we}, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_rd1", rd_data1, 32'h0);
      chk("reset_rd2", rd_data2, 32'h0);
      chk("reset_cnt", retire_cnt, 32'h0);

      // directed table
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(tbl[i].regwr, tbl[i].m2r, tbl[i].dst, tbl[i].alu, tbl[i].mem);
         rd_addr1 = 5'd2;
         #1;
         chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].exp_wd);
         chk($sformatf("tbl%0d_wb_we", i), {31'b0, wb_we}, {31'b0, tbl[i].exp_we});
         @(posedge clk); #1;
         idle();
         rd_addr1 = tbl[i].raddr;
         #1;
         chk($sformatf("tbl%0d_rd1", i), rd_data1, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_cnt", i), retire_cnt, tbl[i].exp_cnt);
      end

      // mid-cycle asynchronous reset clears the array immediately
      write_reg(5'd5, 32'h00001234);
      rd_addr1 = 5'd5;
      #1 chk("pre_reset_r5", rd_data1, 32'h00001234);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_reset_r5", rd_data1, 32'h0);
      chk("async_reset_cnt", retire_cnt, 32'h0);
      @(negedge clk); rst = 1'b0;

      // read-during-write on port 2
      write_reg(5'd3, 32'h00000011);
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 32'h0);
      rd_addr2 = 5'd3;
      #1;
      chk("bypass_same_cycle", rd_data2, BYP ? 32'hDEADBEEF : 32'h00000011);
      @(posedge clk); #1;
      idle();
      #1 chk("bypass_after_edge", rd_data2, 32'hDEADBEEF);
      // no bypass onto r0
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
      rd_addr2 = 5'd0;
      #1 chk("r0_no_bypass", rd_data2, 32'h0);
      idle();

      // counter wrap
      @(negedge clk);
      force dut.retire_cnt_q = 32'hFFFFFFFE;
      #1 release dut.retire_cnt_q;
      write_reg(5'd4, 32'h1);
      chk("cnt_wrap_ffffffff", retire_cnt, 32'hFFFFFFFF);
      write_reg(5'd4, 32'h2);
      chk("cnt_wrap_zero", retire_cnt, 32'h0);

      // write coincident with reset is lost
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd9, 32'h00000077, 32'h0);
      rst = 1'b1; rd_addr2 = 5'd9;
      #1;
      chk("rst_wr_wb_we", {31'b0, wb_we}, 32'h1);
      chk("rst_wr_wb_data", wb_data, 32'h00000077);
      chk("rst_wr_rd2_in_rst", rd_data2, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; idle(); rd_addr1 = 5'd9;
      #1;
      chk("rst_wr_r9", rd_data1, 32'h0);
      chk("rst_wr_cnt", retire_cnt, 32'h0);

      // randomized run against the model (state is all-zero after reset)
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] e_wd, e_r1, e_r2;
         logic        e_we;
         @(negedge clk);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31)),
               $urandom, $urandom);
         rd_addr1 = 5'($urandom_range(0, 31));
         rd_addr2 = ($urandom_range(0, 2) == 0) ? wb_dst : 5'($urandom_range(0, 31));
         #1;
         e_wd = wb_mem2reg ? wb_mem_data : wb_alu_data;
         e_we = wb_regwr && (wb_dst != 5'd0);
         e_r1 = (rd_addr1 == 5'd0) ? 32'h0 :
                (BYP && e_we && rd_addr1 == wb_dst) ? e_wd : m_regs[rd_addr1];
         e_r2 = (rd_addr2 == 5'd0) ? 32'h0 :
                (BYP && e_we && rd_addr2 == wb_dst) ? e_wd : m_regs[rd_addr2];
         chk("rnd_wb_data", wb_data, e_wd);
         chk("rnd_wb_we", {31'b0, wb_we}, {31'b0, e_we});
         chk("rnd_rd1", rd_data1, e_r1);
         chk("rnd_rd2", rd_data2, e_r2);
         chk("rnd_cnt", retire_cnt, m_cnt);
         @(posedge clk);
         if (e_we) begin
            m_regs[wb_dst] = e_wd;
            m_cnt = m_cnt + 32'd1;
         end
      end

      @(negedge clk); idle();
      #1 chk("final_cnt", retire_cnt, m_cnt);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register, together with the 32×32 general-purpose register file it writes. It selects the writeback value (load data or ALU result) and commits it to the destination register on the rising clock edge. It serves the two combinational read ports used by the ID stage. It also exports the writeback value for EX-stage forwarding and keeps a retired-write counter.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wb_alu_data  in  DATA_W  ALU result from MEM/WB
- wb_mem_data  in  DATA_W  load data from MEM/WB
- wb_dst  in  ADDR_W  destination register index
- wb_mem2reg  in  1  1 = write wb_mem_data, 0 = write wb_alu_data
- wb_regwr  in  1  register write enable
- rd_addr1  in  ADDR_W  ID read port 1 address
- rd_addr2  in  ADDR_W  ID read port 2 address
- rd_data1  out  DATA_W  ID read port 1 data
- rd_data2  out  DATA_W  ID read port 2 data
- wb_data  out  DATA_W  selected writeback value, for EX forwarding
- wb_we  out  1  qualified write strobe: wb_regwr && wb_dst != 0
- retire_cnt  out  32  count of committed register writes

## Operation
- Writeback value: wb_data = wb_mem2reg ? wb_mem_data : wb_alu_data. This is combinational.
- Commit: on posedge clk, if wb_we, then regs[wb_dst] <= wb_data.
- Register 0 is hardwired to zero.
  - Writes with wb_dst == 0 are dropped.
  - Reads of address 0 always return 0, including under bypass.
- Reads are combinational: rd_dataN = regs[rd_addrN].
  - Bypass override applies when WB_BYPASS_EN is defined (see Configuration).
- retire_cnt increments by 1 on each posedge with wb_we = 1. It wraps from 0xFFFF_FFFF to 0.
- Reset: rst = 1 asynchronously clears all registers and retire_cnt to 0.
  - While rst is high, no commit occurs; a write presented in the same cycle is lost.
  - rd_data1/2 read 0 during reset.
  - wb_data and wb_we stay combinational functions of their inputs.

## Timing
- Write latency: a value is in the array one edge after wb_we. Without bypass, a read of that register shows the new value in the cycle after the edge.
- Read latency: 0 cycles (combinational from rd_addrN and array state).
- Same-edge conflict: only one write port exists, so there are no write-write conflicts.
- Read-during-write is governed by WB_BYPASS_EN.
- Reset values: regs = 0, retire_cnt = 0, rd_data1 = rd_data2 = 0. wb_data and wb_we follow their inputs.

## Configuration
- WB_BYPASS_EN defined: write-before-read bypass.
  - If wb_we and rd_addrN == wb_dst, then rd_dataN = wb_data in the same cycle.
  - The ID stage needs no extra stall for a WB-to-ID dependency.
- WB_BYPASS_EN undefined: rd_dataN always returns array contents. The hazard unit must stall ID one cycle on a WB-to-ID dependency.

## Structure
- mips_pkg holds DATA_W, ADDR_W, and REG_ZERO (5'd0) as shared constants.
- The MEM/WB pipeline register uses the same package widths.
- Sub-module gpr_array contains:
  - the storage array
  - asynchronous clear
  - a single write port
  - two combinational read ports
  - zero-register masking
- wb_regfile wraps gpr_array and adds:
  - the writeback mux
  - write qualification
  - the bypass logic
  - retire_cnt

## Test plan
- Reset: assert rst mid-cycle after writing r5 = 0x1234 -> rd_data1 (rd_addr1 = 5) = 0 immediately; retire_cnt = 0.
- Mux: wb_regwr = 1, wb_dst = 8, wb_alu_data = 0xAAAA0001, wb_mem_data = 0x5555_0002, wb_mem2reg = 0 -> after edge r8 = 0xAAAA0001. Repeat with wb_mem2reg = 1 -> r8 = 0x55550002.
- Zero register: write wb_dst = 0, data 0xFFFFFFFF -> rd_data1 (addr 0) = 0 and retire_cnt unchanged.
- Bypass: write r3 = 0xDEADBEEF while rd_addr2 = 3.
  - With WB_BYPASS_EN: rd_data2 = 0xDEADBEEF in the same cycle.
  - Without WB_BYPASS_EN: old value in the same cycle, 0xDEADBEEF after the edge.
- Counter wrap: force 0xFFFFFFFE, then two qualified writes -> 0xFFFFFFFF, then 0x00000000.
- Reset during write: wb_we = 1 (r9 = 0x77) coincident with rst -> r9 = 0 and retire_cnt = 0 after rst drops.
